// File: rtl/tt_pwm_pkg.sv
// Shared constants for the multi-channel PWM block: register map, CTRL bits
// and strobe-to-write latency.
package tt_pwm_pkg;

  localparam logic [2:0]  ADDR_PRESC = 3'd6;
  localparam logic [2:0]  ADDR_CTRL  = 3'd7;
  localparam int unsigned CTRL_EN    = 0;
  localparam int unsigned CTRL_INV   = 1;
  localparam int unsigned CTRL_W     = 2;
  localparam int unsigned WR_LAT     = 3;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered duty (shadow/active) and a registered
// compare against the shared period counter.
module pwm_channel #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             wr,
  input  logic             load,
  input  logic             en,
  input  logic             inv,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] shadow,
  output logic             pwm
);

  logic [WIDTH-1:0] active;

  // Active captures the pre-write shadow when a write and a load share an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      active <= '0;
      pwm    <= 1'b0;
    end else if (ce) begin
      if (wr) begin
        shadow <= data;
      end
      if (load) begin
        active <= shadow;
      end
      pwm <= en ? ((cnt < active) ^ inv) : inv;
    end
  end

endmodule

// File: rtl/tt_um_muaz_pwm_multi.sv
// Tiny Tapeout wrapper: multi-channel PWM with strobed register writes,
// shared prescaler/period counter and registered uio readback.
module tt_um_muaz_pwm_multi
  import tt_pwm_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESC_W  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [2:0]          addr_c;
  logic [WR_LAT-1:0]   strobe_sync;
  logic                wr_go;
  logic [PRESC_W-1:0]  presc;
  logic [PRESC_W-1:0]  presc_cnt;
  logic [CTRL_W-1:0]   ctrl;
  logic [WIDTH-1:0]    cnt;
  logic                wrap_pulse;
  logic                en_c;
  logic                inv_c;
  logic                tick_c;
  logic                wrap_c;
  logic                load_c;
  logic [CHANNELS-1:0] pwm;
  logic [WIDTH-1:0]    shadow [CHANNELS];
  logic [7:0]          rd_data_c;
  logic                unused_c;

  assign addr_c   = ui_in[6:4];
  assign en_c     = ctrl[CTRL_EN];
  assign inv_c    = ctrl[CTRL_INV];
  assign tick_c   = en_c && (presc_cnt == presc);
  assign wrap_c   = tick_c && (cnt == '1);
  assign load_c   = wrap_c || !en_c;
  assign unused_c = &{1'b0, ui_in[2:0], uio_in};

  // Two-flop synchroniser plus edge flop; the registered edge lands the write WR_LAT edges after first sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_sync <= '0;
      wr_go       <= 1'b0;
    end else if (ena) begin
      strobe_sync <= {strobe_sync[WR_LAT-2:0], ui_in[7]};
      wr_go       <= strobe_sync[WR_LAT-2] & ~strobe_sync[WR_LAT-1];
    end
  end

  // Global configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      ctrl  <= '0;
    end else if (ena && wr_go) begin
      if (addr_c == ADDR_PRESC) begin
        presc <= uio_in[PRESC_W-1:0];
      end
      if (addr_c == ADDR_CTRL) begin
        ctrl <= uio_in[CTRL_W-1:0];
      end
    end
  end

  // Prescaler and period counter; a prescale count left above a new PRESC runs on to all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt  <= '0;
      cnt        <= '0;
      wrap_pulse <= 1'b0;
    end else if (ena) begin
      wrap_pulse <= wrap_c;
      if (!en_c) begin
        presc_cnt <= '0;
        cnt       <= '0;
      end else begin
        presc_cnt <= (tick_c || (presc_cnt == '1)) ? '0 : presc_cnt + PRESC_W'(1);
        if (tick_c) begin
          cnt <= cnt + WIDTH'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_ch
    pwm_channel #(.WIDTH(WIDTH)) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .ce     (ena),
      .wr     (wr_go && (addr_c == 3'(g)) && (addr_c != ADDR_PRESC) && (addr_c != ADDR_CTRL)),
      .load   (load_c),
      .en     (en_c),
      .inv    (inv_c),
      .data   (uio_in[WIDTH-1:0]),
      .cnt    (cnt),
      .shadow (shadow[g]),
      .pwm    (pwm[g])
    );
  end

  // Readback mux; unmapped addresses read as zero.
  always_comb begin
    rd_data_c = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (addr_c == 3'(i)) begin
        rd_data_c = 8'(shadow[i]);
      end
    end
    if (addr_c == ADDR_PRESC) begin
      rd_data_c = 8'(presc);
    end
    if (addr_c == ADDR_CTRL) begin
      rd_data_c = 8'(ctrl);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uio_out <= '0;
    end else if (ena) begin
      uio_out <= rd_data_c;
    end
  end

  always_comb begin
    uo_out                = '0;
    uo_out[CHANNELS-1:0]  = pwm;
    uo_out[7]             = wrap_pulse;
  end

  assign uio_oe = ui_in[3] ? 8'hFF : 8'h00;

endmodule

// File: tb/tb_tt_um_muaz_pwm_multi.sv
// Scoreboard bench for tt_um_muaz_pwm_multi: per-period high counts and
// readbacks are predicted from register values and checked by a monitor.
module tb_tt_um_muaz_pwm_multi;

  typedef struct packed {
    logic [15:0]      len;
    logic [3:0][15:0] hi;
  } per_t;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   wraps    = 0;
  int   oe_cnt   = 0;
  int   acc_len  = 0;
  int   acc_hi [4];
  per_t exp_q [$];
  logic [7:0] rd_q [$];
  logic [7:0] regs [8];
  per_t e_mon;
  logic [7:0] r_mon;

  tt_um_muaz_pwm_multi dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // One period: length (PRESC+1)*256 clocks, each channel high for (PRESC+1)*duty clocks, complemented when inverted.
  function automatic per_t model(input int unsigned p, input bit inv);
    per_t r;
    r.len = 16'((p + 1) * 256);
    for (int i = 0; i < 4; i++) begin
      int unsigned h;
      h = (p + 1) * regs[i];
      r.hi[i] = 16'(inv ? (p + 1) * 256 - h : h);
    end
    return r;
  endfunction

  // Monitor: a period closes on each wrap pulse; a readback is valid on the second cycle of read enable.
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_len = 0;
      for (int i = 0; i < 4; i++) acc_hi[i] = 0;
      oe_cnt = 0;
    end else begin
      acc_len++;
      for (int i = 0; i < 4; i++) if (uo_out[i]) acc_hi[i]++;
      if (uo_out[7]) begin
        wraps++;
        if (exp_q.size() != 0) begin
          e_mon = exp_q.pop_front();
          chk("period_len", acc_len, e_mon.len);
          for (int i = 0; i < 4; i++) chk($sformatf("ch%0d_high", i), acc_hi[i], e_mon.hi[i]);
        end
        acc_len = 0;
        for (int i = 0; i < 4; i++) acc_hi[i] = 0;
      end
      if (uio_oe == 8'hFF) begin
        oe_cnt++;
        if (oe_cnt == 2 && rd_q.size() != 0) begin
          r_mon = rd_q.pop_front();
          chk("readback", uio_out, r_mon);
        end
      end else begin
        oe_cnt = 0;
      end
    end
  end

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    ui_in[6:4] = a;
    uio_in     = d;
    ui_in[7]   = 1'b1;
    repeat (6) @(posedge clk);
    #1 ui_in[7] = 1'b0;
    repeat (3) @(posedge clk);
    if (a < 3'd4 || a == 3'd6) regs[a] = d;
    else if (a == 3'd7) regs[7] = d & 8'h03;
  endtask

  task automatic rd(input logic [2:0] a);
    rd_q.push_back(regs[a]);
    @(posedge clk); #1;
    ui_in[6:4] = a;
    ui_in[3]   = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ui_in[3] = 1'b0;
  endtask

  task automatic wait_wrap(input int budget);
    int start;
    int n;
    start = wraps;
    n = 0;
    while (wraps == start && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (wraps == start) begin
      n_checks++;
      n_fail++;
      $display("FAIL wrap_timeout: no wrap pulse within %0d cycles", budget);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] snap;
    int         bad;
    int         w0;
    int unsigned p;
    bit         inv;
    logic [2:0] a;

    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    for (int i = 0; i < 8; i++) regs[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_uo_out", uo_out, 0);
    chk("reset_uio_oe", uio_oe, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) rd(3'(i));

    // Write latency: strobe first sampled at edge T, shadow updates on edge T+3.
    @(posedge clk); #1;
    ui_in  = 8'b1_000_1_000;
    uio_in = 8'h40;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("latency_before_t3", uio_out, 8'h00);
    @(posedge clk);
    @(negedge clk);
    chk("latency_at_t3", uio_out, 8'h40);
    @(posedge clk); #1;
    ui_in = 8'h00;
    repeat (3) @(posedge clk);
    regs[0] = 8'h40;

    // Held strobe with data changed afterwards: only the first value lands.
    @(posedge clk); #1;
    ui_in  = 8'b1_010_0_000;
    uio_in = 8'hA0;
    repeat (6) @(posedge clk);
    #1 uio_in = 8'h5A;
    repeat (14) @(posedge clk);
    #1 ui_in[7] = 1'b0;
    repeat (3) @(posedge clk);
    regs[2] = 8'hA0;
    rd(3'd2);

    wr(3'd3, 8'hFF);
    wr(3'd7, 8'h01);
    wait_wrap(300);
    exp_q.push_back(model(0, 0));
    exp_q.push_back(model(0, 0));
    wait_wrap(300);
    wait_wrap(300);

    // Mid-period duty write only affects the following period.
    exp_q.push_back(model(0, 0));
    repeat (100) @(posedge clk);
    wr(3'd0, 8'd192);
    exp_q.push_back(model(0, 0));
    wait_wrap(300);
    wait_wrap(300);

    // Write landing on the wrap edge: two more periods at the old duty.
    exp_q.push_back(model(0, 0));
    exp_q.push_back(model(0, 0));
    repeat (251) @(posedge clk);
    wr(3'd0, 8'd32);
    exp_q.push_back(model(0, 0));
    wait_wrap(300);
    wait_wrap(300);
    wait_wrap(300);

    // ena low for 100 cycles at count ~120: period stretches by 100, held-high channels gain 100.
    begin
      per_t e;
      e = model(0, 0);
      e.len   = e.len + 16'd100;
      e.hi[2] = e.hi[2] + 16'd100;
      e.hi[3] = e.hi[3] + 16'd100;
      exp_q.push_back(e);
    end
    repeat (120) @(posedge clk);
    #1 ena = 1'b0;
    snap = uo_out;
    bad  = 0;
    repeat (100) begin
      @(negedge clk);
      if (uo_out != snap) bad++;
    end
    @(posedge clk);
    #1 ena = 1'b1;
    chk("freeze_changes", bad, 0);
    wait_wrap(500);

    // Prescale 3 with invert.
    wr(3'd7, 8'h00);
    wr(3'd0, 8'd128);
    wr(3'd6, 8'h03);
    rd(3'd6);
    wr(3'd7, 8'h03);
    wait_wrap(1100);
    exp_q.push_back(model(3, 1));
    exp_q.push_back(model(3, 1));
    wait_wrap(1100);
    wait_wrap(1100);

    // Disabled and inverted: constant high PWM, no wrap pulses.
    wr(3'd7, 8'h02);
    w0  = wraps;
    bad = 0;
    repeat (1100) begin
      @(negedge clk);
      if (uo_out != 8'h0F) bad++;
    end
    chk("inv_idle_level", bad, 0);
    chk("inv_idle_wraps", wraps - w0, 0);

    // Randomised configurations.
    for (int r = 0; r < 4; r++) begin
      wr(3'd7, 8'h00);
      p   = $urandom_range(0, 2);
      inv = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) begin
        logic [7:0] d;
        if ($urandom_range(0, 5) == 0) d = 8'h00;
        else if ($urandom_range(0, 5) == 0) d = 8'hFF;
        else d = 8'($urandom_range(0, 255));
        wr(3'(i), d);
      end
      wr(3'd6, 8'(p));
      wr(3'(4 + $urandom_range(0, 1)), 8'($urandom_range(1, 255)));
      rd(3'(4 + $urandom_range(0, 1)));
      a = 3'($urandom_range(0, 7));
      rd(a);
      wr(3'd7, {6'b0, inv, 1'b1});
      wait_wrap(int'((p + 1) * 256 + 50));
      exp_q.push_back(model(p, inv));
      wait_wrap(int'((p + 1) * 256 + 50));
    end

    // Reset mid-period.
    wr(3'd6, 8'h03);
    wr(3'd7, 8'h01);
    repeat (500) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    chk("midreset_uo_out", uo_out, 0);
    chk("midreset_uio_out", uio_out, 0);
    chk("midreset_uio_oe", uio_oe, 0);
    for (int i = 0; i < 8; i++) regs[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    w0 = wraps;
    repeat (1200) @(negedge clk);
    chk("postreset_wraps", wraps - w0, 0);
    for (int i = 0; i < 8; i++) rd(3'(i));

    repeat (4) @(posedge clk);
    chk("period_queue_drained", exp_q.size(), 0);
    chk("read_queue_drained", rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
